// File: rtl/t03_mem_arbiter.sv
// Two-requester (I-refill / D load-store) arbiter onto one wishbone manager port,
// with watchdog abort. Define T03_MEM_ARB_RR_EN for round-robin on simultaneous requests.
module t03_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  input  logic        wb_ack,
  input  logic [31:0] wb_rdata,
  output logic        i_ack,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        wb_read,
  output logic        wb_write,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_sel,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner, r_rd, r_err;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [3:0]       r_sel;

  logic w_d_any, w_any, w_grant_d, w_timeout;

  assign w_d_any = d_read | d_write;
  assign w_any   = w_d_any | i_req;
`ifdef T03_MEM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  assign w_grant_d = w_d_any & (~i_req | ~r_owner);
`else
  assign w_grant_d = w_d_any;
`endif
  // A same-cycle wb_ack takes precedence over the watchdog.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !wb_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (wb_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner <= w_grant_d;
          r_rd    <= w_grant_d ? d_read : 1'b1;
          r_addr  <= w_grant_d ? d_addr : i_addr;
          r_wdata <= (w_grant_d && !d_read) ? d_wdata : 32'h0;
          r_sel   <= (w_grant_d && !d_read) ? d_sel : 4'hF;
          r_err   <= 1'b0;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (wb_ack) begin
            r_rdata <= r_rd ? wb_rdata : 32'h0;
          end else if (w_timeout) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
          end
        end
        S_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign wb_read  = (r_state == S_BUSY) &  r_rd;
  assign wb_write = (r_state == S_BUSY) & ~r_rd;
  assign wb_addr  = r_addr;
  assign wb_wdata = r_wdata;
  assign wb_sel   = r_sel;
  assign i_ack    = (r_state == S_DONE) & ~r_owner;
  assign d_ack    = (r_state == S_DONE) &  r_owner;
  assign err      = (r_state == S_DONE) &  r_err;
  assign rdata    = r_rdata;
  assign owner    = r_owner;

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// Directed self-checking bench for t03_mem_arbiter (built with TIMEOUT=4).
module tb_t03_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 0, d_read = 0, d_write = 0, wb_ack = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, wb_rdata = 0;
  logic [3:0]  d_sel = 0;
  logic        i_ack, d_ack, err, wb_read, wb_write, owner;
  logic [31:0] rdata, wb_addr, wb_wdata;
  logic [3:0]  wb_sel;

  int total = 0, bad = 0;
  logic first_d;

  t03_mem_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .i_ack(i_ack), .d_ack(d_ack), .rdata(rdata), .err(err),
    .wb_read(wb_read), .wb_write(wb_write), .wb_addr(wb_addr),
    .wb_wdata(wb_wdata), .wb_sel(wb_sel), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_strb"}, {30'h0, wb_read, wb_write}, 32'h0);
    chk({tag, "_acks"}, {29'h0, i_ack, d_ack, err}, 32'h0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_strb", {30'h0, wb_read, wb_write}, 32'h0);
    chk("rst_acks", {29'h0, i_ack, d_ack, err}, 32'h0);
    chk("rst_addr", wb_addr, 32'h0);
    chk("rst_misc", {27'h0, wb_sel, owner}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    tick(); rst = 1'b0; tick();

    // reset during BUSY
    i_req = 1; i_addr = 32'h100;
    tick();
    chk("rmid_busy", {31'h0, wb_read}, 32'h1);
    rst = 1'b1;
    tick();
    chk_idle_out("rmid");
    chk("rmid_addr", wb_addr, 32'h0);
    chk("rmid_sel", {28'h0, wb_sel}, 32'h0);
    i_req = 0; rst = 1'b0;
    tick();

    // I read: wb_ack on the 3rd strobe cycle
    i_req = 1; i_addr = 32'h40;
    chk("ird_lat0", {31'h0, wb_read}, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("ird_strb%0d", k), {30'h0, wb_read, wb_write}, 32'h2);
      chk($sformatf("ird_addr%0d", k), wb_addr, 32'h40);
      if (k == 3) begin wb_ack = 1; wb_rdata = 32'h1234_5678; end
      tick();
    end
    wb_ack = 0;
    chk("ird_strb_off", {31'h0, wb_read}, 32'h0);
    chk("ird_acks", {29'h0, i_ack, d_ack, err}, 32'h4);
    chk("ird_rdata", rdata, 32'h1234_5678);
    chk("ird_sel", {28'h0, wb_sel}, 32'hF);
    i_req = 0;
    tick();
    chk_idle_out("ird_post");

    // wb_ack in IDLE is ignored
    wb_ack = 1; tick(); wb_ack = 0;
    chk_idle_out("idle_ack");
    tick();
    chk_idle_out("idle_ack2");

    // D write
    d_write = 1; d_addr = 32'h3000_0004; d_wdata = 32'hCAFE_F00D; d_sel = 4'b0011;
    tick();
    chk("dwr_strb", {30'h0, wb_read, wb_write}, 32'h1);
    chk("dwr_addr", wb_addr, 32'h3000_0004);
    chk("dwr_wdata", wb_wdata, 32'hCAFE_F00D);
    chk("dwr_sel", {28'h0, wb_sel}, 32'h3);
    chk("dwr_owner", {31'h0, owner}, 32'h1);
    d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'hC;
    wb_ack = 1; wb_rdata = 32'hDEAD_BEEF;
    tick();
    wb_ack = 0;
    chk("dwr_acks", {29'h0, i_ack, d_ack, err}, 32'h2);
    chk("dwr_rdata", rdata, 32'h0);
    chk("dwr_strb_off", {30'h0, wb_read, wb_write}, 32'h0);
    d_write = 0;
    tick();
    chk_idle_out("dwr_post");

    // timeout, with read taking precedence over a simultaneous write
    d_read = 1; d_write = 1; d_addr = 32'h200; d_sel = 4'h1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_strb%0d", k), {30'h0, wb_read, wb_write}, 32'h2);
      tick();
    end
    chk("to_strb_off", {30'h0, wb_read, wb_write}, 32'h0);
    chk("to_acks", {29'h0, i_ack, d_ack, err}, 32'h3);
    chk("to_rdata", rdata, 32'h0);
    d_read = 0; d_write = 0;
    tick();
    chk_idle_out("to_post");

    // wb_ack on the timeout cycle wins
    d_read = 1; d_addr = 32'h204;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("col_strb%0d", k), {31'h0, wb_read}, 32'h1);
      if (k == 4) begin wb_ack = 1; wb_rdata = 32'hA5A5_5A5A; end
      tick();
    end
    wb_ack = 0;
    chk("col_acks", {29'h0, i_ack, d_ack, err}, 32'h2);
    chk("col_rdata", rdata, 32'hA5A5_5A5A);
    d_read = 0;
    tick();

    // simultaneous I and D reads; last owner is D
`ifdef T03_MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    i_req = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
    tick();
    chk("sim1_owner", {31'h0, owner}, {31'h0, first_d});
    chk("sim1_addr", wb_addr, first_d ? 32'h200 : 32'h100);
    wb_ack = 1; wb_rdata = 32'h1111_1111;
    tick();
    wb_ack = 0;
    chk("sim1_acks", {30'h0, i_ack, d_ack}, first_d ? 32'h1 : 32'h2);
    chk("sim1_rdata", rdata, 32'h1111_1111);
    if (first_d) d_read = 0; else i_req = 0;
    tick();
    chk_idle_out("sim_gap");
    tick();
    chk("sim2_owner", {31'h0, owner}, {31'h0, ~first_d});
    chk("sim2_addr", wb_addr, first_d ? 32'h100 : 32'h200);
    wb_ack = 1; wb_rdata = 32'h2222_2222;
    tick();
    wb_ack = 0;
    chk("sim2_acks", {30'h0, i_ack, d_ack}, first_d ? 32'h2 : 32'h1);
    chk("sim2_rdata", rdata, 32'h2222_2222);
    i_req = 0; d_read = 0;
    tick();
    chk_idle_out("sim_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/t03_mem_arbiter.md
Name: t03_mem_arbiter

Overview:
- Shares the single wishbone manager port between two requesters:
  - instruction-cache refill port (I), driven by the cached request unit on an instruction miss;
  - data port (D), driven by load/store traffic.
- Latches the winning request, holds it stable on the manager port until ack, then returns the read data and a one-cycle ack pulse to the winner only.
- A watchdog counter aborts hung transactions.

Parameters:
- TIMEOUT, 255, cycles in BUSY before abort; 0 disables the watchdog.
- CNT_W, 8, counter width; requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  I-port read request; level, held until i_ack
- i_addr  in  32  I-port word address
- d_read  in  1  D-port read request; level
- d_write  in  1  D-port write request; level; d_read takes precedence if both high
- d_addr  in  32  D-port address
- d_wdata  in  32  D-port write data
- d_sel  in  4  D-port byte enables
- wb_ack  in  1  manager transaction complete
- wb_rdata  in  32  manager read data, valid with wb_ack
- i_ack  out  1  one-cycle completion pulse to I
- d_ack  out  1  one-cycle completion pulse to D
- rdata  out  32  registered read data, valid during i_ack/d_ack
- err  out  1  one-cycle pulse with the ack when the transaction timed out
- wb_read  out  1  manager read strobe, level
- wb_write  out  1  manager write strobe, level
- wb_addr  out  32  latched address
- wb_wdata  out  32  latched write data
- wb_sel  out  4  latched byte enables; 4'hF for reads
- owner  out  1  0 = I, 1 = D; current or last grant, for debug and MMIO

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; owner 0. Reset mid-transaction drops wb_read/wb_write on the next edge and no ack is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Any request present: pick winner, register addr/wdata/sel/op and owner, go BUSY. Strobes rise the cycle after the request is first seen, so minimum request-to-strobe latency is 1 cycle.
  - Fixed priority: D over I.
- BUSY:
  - wb_read or wb_write held high; wb_addr/wb_wdata/wb_sel held constant regardless of requester inputs.
  - Counter increments each cycle.
  - On wb_ack: capture wb_rdata into rdata (0 for writes), drop strobes, go DONE.
  - TIMEOUT != 0 and counter == TIMEOUT-1 without wb_ack: drop strobes, set rdata = 32'h0, flag err, go DONE.
  - wb_ack on the same cycle as the timeout wins; err stays 0.
- DONE:
  - Exactly one cycle. Assert the winner's ack (i_ack or d_ack) and err if flagged; clear counter; go IDLE.
  - New requests are not sampled in DONE, so the requester can deassert on its ack.
- Requester deasserting during BUSY does not cancel; the transaction completes and the ack is still pulsed.
- Minimum transaction: request cycle N, strobe N+1, wb_ack N+1, ack N+2, next grant can be latched at N+3.
- wb_ack while in IDLE or DONE is ignored.
- Never both i_ack and d_ack in the same cycle; never both wb_read and wb_write.

Optional Feature:
- Macro: T03_MEM_ARB_RR_EN
- Defined: round-robin when I and D request in the same IDLE cycle; the port not granted last wins. Single requester is still granted immediately.
- Undefined: fixed D-over-I priority; owner is unused for arbitration.

Test Plan:
- Reset mid-BUSY: i_req at 0x100, rst asserted before wb_ack -> strobes 0 next edge, no i_ack, outputs all 0.
- I read alone: i_req, i_addr = 0x0000_0040, wb_ack with rdata 0x1234_5678 three cycles after strobe -> wb_read=1 for exactly 3 cycles, wb_addr=0x40, i_ack one cycle with rdata=0x1234_5678, d_ack=0.
- D write: d_write, addr 0x3000_0004, wdata 0xCAFE_F00D, sel 4'b0011 -> wb_write=1, wb_sel=0011, d_ack one cycle later, rdata=0.
- Simultaneous i_req and d_read:
  - Without macro: D served first, then I; two acks in separate cycles.
  - With T03_MEM_ARB_RR_EN and last owner D: I served first.
- Timeout: TIMEOUT=4, d_read with no wb_ack -> strobe high exactly 4 cycles, then d_ack and err one cycle, rdata=0.
- Ack/timeout collision: wb_ack on the 4th BUSY cycle with TIMEOUT=4 -> err=0, rdata = wb_rdata.
